// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO write-side controller:
// packet FSM state encoding and default statistics counter width.
package fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } wr_state_t;

  localparam int CNTW_DEF = 16;

endpackage

// File: rtl/fifo_skid2.sv
// Two-entry in-order holding buffer between upstream and the FIFO memory.
// Push and pop in the same cycle leave occupancy unchanged.
module fifo_skid2 #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic [1:0]   o_occ
);

  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_occ;

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (i_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({i_push, i_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_dout = r_mem[r_rd_ptr];
  assign o_occ  = r_occ;

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Packet-aware FIFO write controller: buffers upstream words, drops whole packets
// that start while the FIFO is full (DROP_EN=1), and keeps packet/drop statistics.
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int DSIZE   = 8,
  parameter int DROP_EN = 1,
  parameter int CNTW    = CNTW_DEF
) (
  input  logic             wclk,
  input  logic             wrst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [DSIZE-1:0] s_data,
  input  logic             s_last,
  output logic             winc,
  output logic [DSIZE-1:0] wdata,
  input  logic             wfull,
  output logic [CNTW-1:0]  pkt_cnt,
  output logic [CNTW-1:0]  drop_cnt
);

  wr_state_t       r_state;
  logic [CNTW-1:0] r_pkt_cnt;
  logic [CNTW-1:0] r_drop_cnt;

  logic [1:0]      w_occ;
  logic [DSIZE:0]  w_head;
  logic            w_accept;
  logic            w_full_start;
  logic            w_push;
  logic            w_drop_done;

  // In DROP nothing is buffered, so upstream is drained regardless of occupancy.
  assign s_ready      = ~wrst & ((w_occ < 2'd2) | (r_state == ST_DROP));
  assign w_accept     = s_valid & s_ready;
  assign w_full_start = (DROP_EN != 0) && wfull;

  always_comb begin
    w_push      = 1'b0;
    w_drop_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_push      = w_accept & ~w_full_start;
        w_drop_done = w_accept & s_last & w_full_start;
      end
      ST_PASS: w_push      = w_accept;
      ST_DROP: w_drop_done = w_accept & s_last;
      default: ;
    endcase
  end

  fifo_skid2 #(
    .W (DSIZE + 1)
  ) u_skid (
    .clk    (wclk),
    .rst    (wrst),
    .i_push (w_push),
    .i_din  ({s_last, s_data}),
    .i_pop  (winc),
    .o_dout (w_head),
    .o_occ  (w_occ)
  );

  assign winc  = (w_occ != 2'd0) & ~wfull;
  assign wdata = w_head[DSIZE-1:0];

  always_ff @(posedge wclk) begin
    if (wrst) begin
      r_state    <= ST_IDLE;
      r_pkt_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_accept) begin
        case (r_state)
          ST_IDLE: begin
            if (!s_last) begin
              if (w_full_start) begin
                r_state <= ST_DROP;
              end else begin
                r_state <= ST_PASS;
              end
            end
          end
          ST_PASS, ST_DROP: begin
            if (s_last) begin
              r_state <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
      if (winc && w_head[DSIZE] && (r_pkt_cnt != '1)) begin
        r_pkt_cnt <= r_pkt_cnt + CNTW'(1);
      end
      if (w_drop_done && (r_drop_cnt != '1)) begin
        r_drop_cnt <= r_drop_cnt + CNTW'(1);
      end
    end
  end

  assign pkt_cnt  = r_pkt_cnt;
  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Bench for fifo_wr_ctrl: directed vector table, hand-written corner sequences,
// and random traffic against a packet-level queue model.
module tb_fifo_wr_ctrl;

  logic wclk = 1'b0;
  always #5 wclk = ~wclk;

  logic       wrst, s_valid, s_last, wfull;
  logic [7:0] s_data;

  logic        rdy0, rdy1, rdy2, winc0, winc1, winc2;
  logic [7:0]  wd0, wd1, wd2;
  logic [15:0] pkt0, drop0, pkt1, drop1;
  logic [3:0]  pkt2, drop2;

  fifo_wr_ctrl dut0 (
    .wclk(wclk), .wrst(wrst), .s_valid(s_valid), .s_ready(rdy0), .s_data(s_data),
    .s_last(s_last), .winc(winc0), .wdata(wd0), .wfull(wfull),
    .pkt_cnt(pkt0), .drop_cnt(drop0)
  );
  fifo_wr_ctrl #(.DROP_EN(0)) dut1 (
    .wclk(wclk), .wrst(wrst), .s_valid(s_valid), .s_ready(rdy1), .s_data(s_data),
    .s_last(s_last), .winc(winc1), .wdata(wd1), .wfull(wfull),
    .pkt_cnt(pkt1), .drop_cnt(drop1)
  );
  fifo_wr_ctrl #(.CNTW(4)) dut2 (
    .wclk(wclk), .wrst(wrst), .s_valid(s_valid), .s_ready(rdy2), .s_data(s_data),
    .s_last(s_last), .winc(winc2), .wdata(wd2), .wfull(wfull),
    .pkt_cnt(pkt2), .drop_cnt(drop2)
  );

  // Instances share stimulus; only the selected one is observed and modelled.
  int          sel;
  logic        o_rdy, o_winc;
  logic [7:0]  o_wd;
  logic [15:0] o_pkt, o_drop;

  always_comb begin
    o_rdy = rdy0; o_winc = winc0; o_wd = wd0; o_pkt = pkt0; o_drop = drop0;
    if (sel == 1) begin
      o_rdy = rdy1; o_winc = winc1; o_wd = wd1; o_pkt = pkt1; o_drop = drop1;
    end else if (sel == 2) begin
      o_rdy = rdy2; o_winc = winc2; o_wd = wd2;
      o_pkt = {12'd0, pkt2}; o_drop = {12'd0, drop2};
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Packet-level reference: queue of words kept but not yet written, plus packet flags.
  logic [8:0] mq[$];
  logic       m_in_pkt, m_dropping, m_drop_en, last_acc;
  int         m_pkt, m_drop, m_max;

  task automatic model_reset();
    mq.delete();
    m_in_pkt = 0; m_dropping = 0; m_pkt = 0; m_drop = 0;
  endtask

  task automatic configure(input int s);
    sel       = s;
    m_drop_en = (s != 1);
    m_max     = (s == 2) ? 15 : 65535;
  endtask

  task automatic cycle();
    logic       er, ew;
    logic [8:0] hd;
    @(negedge wclk);
    er = !wrst && (mq.size() < 2 || m_dropping);
    ew = (mq.size() > 0) && !wfull;
    chk("s_ready", o_rdy, er);
    chk("winc", o_winc, ew);
    if (ew) begin
      hd = mq[0];
      chk("wdata", o_wd, hd[7:0]);
    end
    chk("pkt_cnt", o_pkt, m_pkt);
    chk("drop_cnt", o_drop, m_drop);
    last_acc = 0;
    if (wrst) begin
      model_reset();
    end else begin
      if (ew) begin
        hd = mq.pop_front();
        if (hd[8] && m_pkt < m_max) m_pkt++;
      end
      if (s_valid && er) begin
        last_acc = 1;
        if (m_dropping) begin
          if (s_last) begin
            m_dropping = 0;
            if (m_drop < m_max) m_drop++;
          end
        end else if (m_in_pkt) begin
          mq.push_back({s_last, s_data});
          if (s_last) m_in_pkt = 0;
        end else if (m_drop_en && wfull) begin
          if (s_last) begin
            if (m_drop < m_max) m_drop++;
          end else begin
            m_dropping = 1;
          end
        end else begin
          mq.push_back({s_last, s_data});
          m_in_pkt = !s_last;
        end
      end
    end
    @(posedge wclk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic wf);
    s_valid = v; s_data = d; s_last = l; wfull = wf;
    cycle();
  endtask

  task automatic do_reset();
    wrst = 1; s_valid = 0; s_data = 0; s_last = 0; wfull = 0;
    @(posedge wclk);
    #1;
    model_reset();
    cycle();
    wrst = 0;
  endtask

  task automatic rand_run(input int n, input int wf_pct);
    int rem;
    rem = $urandom_range(1, 4);
    s_valid = 0; last_acc = 0;
    for (int c = 0; c < n; c++) begin
      if (!(s_valid && !last_acc)) begin
        if (s_valid && last_acc) begin
          rem--;
          if (rem == 0) rem = $urandom_range(1, 4);
        end
        s_valid = ($urandom_range(0, 3) != 0);
        s_data  = 8'($urandom);
        s_last  = (rem == 1);
      end
      wfull = ($urandom_range(0, 99) < wf_pct);
      cycle();
    end
  endtask

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       l;
    logic       wf;
    logic       rdy;
    logic       winc;
    logic [7:0] wd;
    int         pkt;
    int         drop;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic [7:0] d, input logic l, input logic wf,
                     input logic rdy, input logic wi, input logic [7:0] wd,
                     input int pkt, input int drop);
    vec_t e;
    e.v = v; e.d = d; e.l = l; e.wf = wf;
    e.rdy = rdy; e.winc = wi; e.wd = wd; e.pkt = pkt; e.drop = drop;
    tbl.push_back(e);
  endtask

  logic [7:0] words [3];
  int         idx;

  initial begin
    // 4-word packet at full rate, then a dropped 3-word packet, a dropped
    // single-word packet, and a 5-word packet stalled mid-flight by wfull.
    add(1, 8'h11, 0, 0,  1, 0, 8'h00, 0, 0);
    add(1, 8'h12, 0, 0,  1, 1, 8'h11, 0, 0);
    add(1, 8'h13, 0, 0,  1, 1, 8'h12, 0, 0);
    add(1, 8'h14, 1, 0,  1, 1, 8'h13, 0, 0);
    add(0, 8'h00, 0, 0,  1, 1, 8'h14, 0, 0);
    add(0, 8'h00, 0, 0,  1, 0, 8'h00, 1, 0);
    add(1, 8'h21, 0, 1,  1, 0, 8'h00, 1, 0);
    add(1, 8'h22, 0, 1,  1, 0, 8'h00, 1, 0);
    add(1, 8'h23, 1, 0,  1, 0, 8'h00, 1, 0);
    add(0, 8'h00, 0, 0,  1, 0, 8'h00, 1, 1);
    add(1, 8'h31, 1, 1,  1, 0, 8'h00, 1, 1);
    add(0, 8'h00, 0, 0,  1, 0, 8'h00, 1, 2);
    add(1, 8'h41, 0, 0,  1, 0, 8'h00, 1, 2);
    add(1, 8'h42, 0, 0,  1, 1, 8'h41, 1, 2);
    add(1, 8'h43, 0, 1,  1, 0, 8'h00, 1, 2);
    for (int k = 0; k < 5; k++) add(1, 8'h44, 0, 1,  0, 0, 8'h00, 1, 2);
    add(1, 8'h44, 0, 0,  0, 1, 8'h42, 1, 2);
    add(1, 8'h44, 0, 0,  1, 1, 8'h43, 1, 2);
    add(1, 8'h45, 1, 0,  1, 1, 8'h44, 1, 2);
    add(0, 8'h00, 0, 0,  1, 1, 8'h45, 1, 2);
    add(0, 8'h00, 0, 0,  1, 0, 8'h00, 2, 2);

    configure(0);
    do_reset();

    for (int i = 0; i < tbl.size(); i++) begin
      s_valid = tbl[i].v; s_data = tbl[i].d; s_last = tbl[i].l; wfull = tbl[i].wf;
      @(negedge wclk);
      chk($sformatf("vec%0d_rdy", i), o_rdy, tbl[i].rdy);
      chk($sformatf("vec%0d_winc", i), o_winc, tbl[i].winc);
      if (tbl[i].winc) chk($sformatf("vec%0d_wdata", i), o_wd, tbl[i].wd);
      chk($sformatf("vec%0d_pkt", i), o_pkt, tbl[i].pkt);
      chk($sformatf("vec%0d_drop", i), o_drop, tbl[i].drop);
      @(posedge wclk);
      #1;
    end

    // Reset with two words of an open packet buffered behind a full FIFO.
    do_reset();
    drive(1, 8'h51, 0, 0);
    drive(1, 8'h52, 0, 1);
    s_valid = 0; wrst = 1;
    cycle();
    cycle();
    chk("rst_mid_winc", o_winc, 0);
    wrst = 0;
    drive(0, 8'h00, 0, 0);
    drive(1, 8'h61, 1, 0);
    drive(0, 8'h00, 0, 0);
    drive(0, 8'h00, 0, 0);
    chk("rst_mid_pkt", o_pkt, 1);

    // No-drop variant: full at packet start only backpressures.
    configure(1);
    do_reset();
    words[0] = 8'h71; words[1] = 8'h72; words[2] = 8'h73;
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      wfull   = (c < 10);
      s_valid = (idx < 3);
      s_data  = words[idx % 3];
      s_last  = (idx == 2);
      cycle();
      if (last_acc) idx++;
    end
    chk("nodrop_drop", o_drop, 0);
    chk("nodrop_pkt", o_pkt, 1);

    // Narrow counters: seventeen dropped single-word packets saturate at 0xF.
    configure(2);
    do_reset();
    for (int k = 0; k < 17; k++) drive(1, 8'(k), 1, 1);
    drive(0, 8'h00, 0, 1);
    chk("sat_drop", o_drop, 15);

    configure(0);
    do_reset();
    rand_run(1500, 30);
    configure(1);
    do_reset();
    rand_run(800, 40);
    configure(2);
    do_reset();
    rand_run(600, 50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_ctrl.md
FIFO_WR_CTRL -- requirements
Module: fifo_wr_ctrl

Interface
REQ-001 SHALL have parameter DSIZE, default 8, data word width.
REQ-002 SHALL have parameter DROP_EN, default 1; 1 discards packets that start while the FIFO is full, 0 applies backpressure only.
REQ-003 SHALL have parameter CNTW, default 16, statistics counter width.
REQ-004 Port list, clock and reset first:
- wclk  in  1  write-domain clock; one clock, all logic on its rising edge.
- wrst  in  1  reset, synchronous, active-high.
- s_valid  in  1  upstream word valid.
- s_ready  out  1  upstream ready.
- s_data  in  DSIZE  upstream word.
- s_last  in  1  last word of a packet.
- winc  out  1  write strobe to the FIFO write-pointer stage.
- wdata  out  DSIZE  word to the FIFO memory, valid when winc=1.
- wfull  in  1  registered FIFO full flag.
- pkt_cnt  out  CNTW  packets fully written.
- drop_cnt  out  CNTW  packets discarded.

Function
REQ-005 Upstream transfer SHALL occur on a cycle with s_valid=1 and s_ready=1; s_data and s_last are sampled on that edge.
REQ-006 A 2-entry skid buffer SHALL hold accepted words with their last flags; s_ready SHALL be 1 when occupancy<2, or when state=DROP, and derived only from registers.
REQ-007 winc SHALL equal (occupancy>0) AND NOT wfull; wdata SHALL be the buffer head; winc SHALL be 0 whenever wfull=1.
REQ-008 winc/wdata SHALL NOT depend combinationally on any FIFO output other than wfull (no loop through the almost-full path).
REQ-009 A word accepted at edge t with an empty buffer SHALL present winc=1 at cycle t+1 if wfull=0.
REQ-010 Simultaneous accept and write SHALL keep occupancy unchanged and preserve order; sustained throughput SHALL be 1 word/cycle while wfull=0.
REQ-011 The FSM SHALL use states IDLE (expect first word), PASS (mid-packet), DROP (discarding).
REQ-012 IDLE: accepted word with s_last=0 -> DROP if DROP_EN=1 and wfull=1, else buffered and -> PASS; s_last=1 with the same full condition is discarded, stays IDLE and counts a drop.
REQ-013 PASS: words SHALL be buffered; accepted word with s_last=1 -> IDLE.
REQ-014 DROP: accepted words SHALL NOT be buffered; accepted word with s_last=1 -> IDLE and drop_cnt increments.
REQ-015 Words of a packet that entered PASS SHALL never be discarded; a full FIFO mid-packet SHALL only backpressure.
REQ-016 pkt_cnt SHALL increment on each winc with a head word whose last flag=1.
REQ-017 pkt_cnt and drop_cnt SHALL saturate at 2^CNTW-1.
REQ-018 With DROP_EN=0, the drop condition never applies and drop_cnt SHALL stay 0.

Reset
REQ-019 On wrst=1 at an edge: state=IDLE, occupancy=0, s_ready=0 during reset then 1 on the first cycle after, winc=0, pkt_cnt=0, drop_cnt=0; wdata contents are don't-care.
REQ-020 Reset mid-packet SHALL discard buffered words without issuing winc; the next accepted word is a packet start.

Structure
REQ-021 The FSM state encoding and the CNTW default SHALL live in shared package fifo_pkg.
REQ-022 The skid buffer SHALL be the sub-module fifo_skid2 (DSIZE+1 wide, 2 entries); FSM and counters stay in fifo_wr_ctrl.

Verification
REQ-023 Scenario: wfull=0, 4-word packet 0x11..0x14 back-to-back -> winc high cycles 1-4 after the first accept, wdata 0x11..0x14 in order, pkt_cnt=1.
REQ-024 Scenario: wfull=1 at first word, DROP_EN=1, 3-word packet -> all 3 accepted with s_ready=1, winc never 1, drop_cnt=1, state IDLE after.
REQ-025 Scenario: wfull rises after word 2 of a 5-word packet for 6 cycles -> s_ready falls after 2 buffered words, no loss, all 5 words written in order, drop_cnt=0.
REQ-026 Scenario: DROP_EN=0, wfull=1 at packet start for 10 cycles -> no drop, words written after wfull falls, drop_cnt=0.
REQ-027 Scenario: wrst pulsed with 2 words buffered mid-packet -> occupancy 0, winc 0, counters 0, next packet written normally.
REQ-028 Scenario: drop_cnt preloaded near saturation with CNTW=4, 17 dropped single-word packets -> drop_cnt holds 0xF.
